dmem_line_server: RTL and testbench
===================================

# dmem_line_server

Backing-memory responder for the data cache's miss path. Accepts line-refill and line-writeback requests from the cache over a valid/ready handshake. Serves refills as fixed-latency bursts of ascending words and absorbs writebacks word by word. Sits between the cache and the word-addressed data store.

## Interface
- `LINE_WORDS`, 4: words per cache line, power of two, ≥2.
- `DEPTH_WORDS`, 1024: storage depth in 32-bit words, power of two.
- `LATENCY`, 3: cycles from request acceptance to first refill word, ≥1.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: cache presents a request.
- `req_write` in 1: 1 = writeback, 0 = refill.
- `req_addr` in 32: byte address of the line.
- `req_ready` out 1: responder can accept a request.
- `wdata_valid` in 1: writeback word present.
- `wdata` in 32: writeback word.
- `wdata_ready` out 1: responder accepts a writeback word this cycle.
- `rdata_valid` out 1: refill word valid.
- `rdata` out 32: refill word.
- `rdata_last` out 1: final word of the refill burst.
- `wr_done` out 1: one-cycle pulse when a writeback is fully stored.

## Operation
- FSM states: IDLE, WAIT, RBURST, WBURST, DONE.
- **IDLE**
  - `req_ready`=1.
  - Accept on `req_valid`&&`req_ready`. Latch the line base and the direction.
  - Refill → WAIT. Writeback → WBURST.
- **Line base**
  - Word index = (`req_addr`>>2) with the low log2(LINE_WORDS) bits forced to 0, taken modulo DEPTH_WORDS.
  - Upper address bits are ignored, so the index wraps.
- **WAIT**
  - Countdown of LATENCY-1 cycles, then → RBURST.
- **RBURST**
  - Emit LINE_WORDS words on consecutive cycles at base+0 … base+LINE_WORDS-1, ascending.
  - No backpressure: the cache must sink one word per cycle.
  - `rdata_last`=1 with the final word, then → IDLE.
- **WBURST**
  - `wdata_ready`=1.
  - Each cycle with `wdata_valid`: store `wdata` at base+count and increment count. Gaps (valid low) are allowed.
  - After the LINE_WORDS-th word → DONE.
- **DONE**
  - `wr_done`=1 for one cycle, then → IDLE.
- Only one request is outstanding. `req_ready`=0 in every state except IDLE.
- `wdata_valid` outside WBURST is ignored.
- A refill issued immediately after a writeback to the same line returns the newly written data.
- Storage is not cleared by reset.
  - A reset mid-WBURST leaves already-stored words in place; the rest keep their old contents.
  - A reset mid-RBURST truncates the burst, and no `rdata_last` is issued.
- Reset values:
  - state IDLE, counters 0.
  - `req_ready`=1.
  - `wdata_ready`, `rdata_valid`, `rdata_last`, `wr_done` = 0.
  - `rdata`=0.

## Timing
- Request accepted at edge T. The first refill word is valid in cycle T+LATENCY.
- The last refill word is valid in cycle T+LATENCY+LINE_WORDS-1.
- `req_ready` returns to 1 in the cycle after `rdata_last`.
- Writeback with back-to-back words: the first word can be taken in cycle T+1. With LINE_WORDS words and no gaps, `wr_done` is high in cycle T+LINE_WORDS+1. `req_ready` returns to 1 the cycle after.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Storage read is synchronous, one cycle. The read address is issued one cycle before each RBURST beat.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE, WAIT, RBURST, WBURST, DONE);
  - the default constants for `LINE_WORDS`, `DEPTH_WORDS` and `LATENCY`.
- The cache controller imports the same package so both ends agree on line size.
- One natural sub-module, `dmem_word_ram`: single-port synchronous 32-bit RAM with write enable, inferable as block RAM.
- The FSM, latency counter, beat counter and address generation stay in the top level.

## Test plan
- **Refill after reset:** preload words 0x10..0x13 with 0xA0..0xA3. Send refill `req_addr`=0x40.
  - Expect `rdata_valid` starting 3 cycles after acceptance.
  - Expect `rdata` 0xA0, 0xA1, 0xA2, 0xA3 in ascending order.
  - Expect `rdata_last` only on 0xA3.
- **Unaligned address and wrap:**
  - Refill `req_addr`=0x4C returns the same four words as 0x40.
  - `req_addr`=0x1040 (index 1040 mod 1024 = 16) also returns 0xA0..0xA3.
- **Writeback with gaps:** writeback to 0x80 with words 0x11, 0x22, 0x33, 0x44, `wdata_valid` low on alternate cycles.
  - Expect `wr_done` one cycle after the 4th word is taken.
  - A following refill of 0x80 returns 0x11..0x44.
- **Single outstanding request:** hold `req_valid` continuously.
  - Expect `req_ready`=0 throughout WAIT and RBURST.
  - Expect the second request to be accepted only in the cycle after `rdata_last`.
- **Reset mid-writeback:** assert `rst` after 2 of 4 writeback words to 0xC0, which held 0xF0..0xF3.
  - Expect all outputs at their reset values immediately.
  - A subsequent refill returns new0, new1, 0xF2, 0xF3.
- **Stray write data:** `wdata_valid` toggled during IDLE and RBURST.
  - Expect no storage change and `wdata_ready`=0.

Source files
------------

// File: rtl/dmem_line_server_pkg.sv
// Shared definitions for the data-memory line server and its cache-side peer.
// Both ends take the line size from here so they agree on burst length.
package dmem_line_server_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE
  } state_t;

  localparam int DEF_LINE_WORDS  = 4;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_LATENCY     = 3;

endpackage

// File: rtl/dmem_word_ram.sv
// Single-port synchronous 32-bit word store, read-first, no reset so it maps
// onto block RAM; contents survive a system reset.
module dmem_word_ram
  import dmem_line_server_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/dmem_line_server.sv
// Line refill/writeback responder for the data cache miss path.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
module dmem_line_server
  import dmem_line_server_pkg::*;
#(
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        wdata_valid,
  input  logic [31:0] wdata,
  output logic        wdata_ready,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        rdata_last,
  output logic        wr_done
);

  localparam int AW      = $clog2(DEPTH_WORDS);
  localparam int BW      = $clog2(LINE_WORDS);
  localparam int LINE_AW = AW - BW;
  localparam int LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(LINE_WORDS - 1);

  state_t             state;
  logic [LINE_AW-1:0] line;
  logic [BW-1:0]      beat;
  logic [BW-1:0]      beat_next;
  logic [LAT_W-1:0]   lat_cnt;

  logic [AW-1:0]      ram_addr;
  logic               ram_we;
  logic [31:0]        ram_q;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[BW+1:0]};
  assign beat_next        = beat + BW'(1);
  assign ram_we           = (state == WBURST) && wdata_valid;

  // Reads run one word ahead of the beat being presented, so the RAM's
  // registered output lines up with rdata_valid.
  always_comb begin
    ram_addr = {req_addr[AW+1:BW+2], {BW{1'b0}}};
    case (state)
      WAIT:    ram_addr = {line, {BW{1'b0}}};
      RBURST:  ram_addr = {line, beat_next};
      WBURST:  ram_addr = {line, beat};
      default: ;
    endcase
  end

  dmem_word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata),
    .q    (ram_q)
  );

  assign rdata = rdata_valid ? ram_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      line        <= '0;
      beat        <= '0;
      lat_cnt     <= '0;
      req_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            line      <= req_addr[AW+1:BW+2];
            beat      <= '0;
            req_ready <= 1'b0;
            if (req_write) begin
              state       <= WBURST;
              wdata_ready <= 1'b1;
            end else if (LATENCY == 1) begin
              state       <= RBURST;
              rdata_valid <= 1'b1;
            end else begin
              state   <= WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state       <= RBURST;
            rdata_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RBURST: begin
          if (beat == LAST_BEAT) begin
            state       <= IDLE;
            beat        <= '0;
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            req_ready   <= 1'b1;
          end else begin
            beat       <= beat_next;
            rdata_last <= (beat_next == LAST_BEAT);
          end
        end
        WBURST: begin
          if (wdata_valid) begin
            if (beat == LAST_BEAT) begin
              state       <= DONE;
              beat        <= '0;
              wdata_ready <= 1'b0;
              wr_done     <= 1'b1;
            end else begin
              beat <= beat_next;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          wr_done   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_server.sv
// Directed bench for dmem_line_server: timing-rule model checked every cycle
// plus literal expectations on refill data, latency and handshake timing.
module tb_dmem_line_server;

  localparam int L     = 3;
  localparam int LW    = 4;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        wdata_valid = 1'b0;
  logic [31:0] wdata = '0;
  logic        wdata_ready;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        wr_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  dmem_line_server #(
    .LINE_WORDS (LW),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .wdata_valid(wdata_valid),
    .wdata      (wdata),
    .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .rdata_last (rdata_last),
    .wr_done    (wr_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // checkers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // behavioural model: word array plus the time offset since acceptance
  typedef enum {M_IDLE, M_RD, M_WR} mmode_t;
  logic [31:0] model_mem [DEPTH];
  mmode_t mmode = M_IDLE;
  int t_acc = 0;
  int taken = 0;
  int mbase = 0;

  function automatic int line_base(input logic [31:0] a);
    return int'((((a >> 2) / LW) * LW) % DEPTH);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mmode = M_IDLE;
      end else begin
        case (mmode)
          M_IDLE: if (req_valid) begin
            t_acc = cyc;
            mbase = line_base(req_addr);
            taken = 0;
            mmode = req_write ? M_WR : M_RD;
          end
          M_RD: if (cyc - t_acc >= L + LW - 1) mmode = M_IDLE;
          M_WR: begin
            if (taken == LW) begin
              mmode = M_IDLE;
            end else if (wdata_valid) begin
              model_mem[mbase + taken] = wdata;
              taken++;
            end
          end
          default: mmode = M_IDLE;
        endcase
      end
    end
  end

  // compare process: every cycle, away from the active edge
  initial begin
    logic e_rr, e_wr, e_rv, e_rl, e_wd;
    logic [31:0] e_rd;
    int d, b;
    forever begin
      @(negedge clk);
      e_rr = 1'b1; e_wr = 1'b0; e_rv = 1'b0; e_rl = 1'b0; e_wd = 1'b0; e_rd = '0;
      if (!rst) begin
        case (mmode)
          M_RD: begin
            e_rr = 1'b0;
            d = cyc - t_acc;
            if (d >= L - 1) begin
              b    = d - (L - 1);
              e_rv = 1'b1;
              e_rd = model_mem[mbase + b];
              e_rl = (b == LW - 1);
            end
          end
          M_WR: begin
            e_rr = 1'b0;
            e_wr = (taken < LW);
            e_wd = (taken == LW);
          end
          default: ;
        endcase
      end
      check1("req_ready", req_ready, e_rr);
      check1("wdata_ready", wdata_ready, e_wr);
      check1("rdata_valid", rdata_valid, e_rv);
      check1("rdata_last", rdata_last, e_rl);
      check1("wr_done", wr_done, e_wd);
      if (e_rv || rst) check("rdata", rdata, e_rd);
    end
  end

  // capture of refill beats for the literal checks
  logic [31:0] cap_q[$];
  logic [31:0] exp_q[$];
  int cap_last_idx = -1;
  int cap_first_cyc = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (rdata_valid === 1'b1) begin
        if (cap_q.size() == 0) cap_first_cyc = cyc;
        cap_q.push_back(rdata);
        if (rdata_last === 1'b1) cap_last_idx = cap_q.size() - 1;
      end
    end
  end

  task automatic cap_clear();
    cap_q.delete();
    cap_last_idx  = -1;
    cap_first_cyc = -1;
  endtask

  task automatic check_burst(input string name, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3, input int acc);
    logic [31:0] e;
    exp_q.delete();
    exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3);
    check({name, "_len"}, 32'(cap_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      if (i < cap_q.size()) check({name, "_data"}, cap_q[i], e);
    end
    check({name, "_last_pos"}, 32'(cap_last_idx), 32'd3);
    check({name, "_latency"}, 32'(cap_first_cyc + 1 - acc), 32'd3);
  endtask

  // drivers
  task automatic send_req(input logic wr, input logic [31:0] addr, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) check1("accept_timeout", req_ready, 1'b1);
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic wb(input logic [31:0] addr, input logic [31:0] w0, input logic [31:0] w1,
                    input logic [31:0] w2, input logic [31:0] w3, input bit gaps);
    logic [31:0] w [4];
    int acc;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    send_req(1'b1, addr, acc);
    for (int i = 0; i < 4; i++) begin
      wdata_valid = 1'b1;
      wdata = w[i];
      @(negedge clk);
      if (gaps && i < 3) begin
        wdata_valid = 1'b0;
        wdata = $urandom;
        @(negedge clk);
      end
    end
    wdata_valid = 1'b0;
    check1("wr_done_pulse", wr_done, 1'b1);
    if (!gaps) check("wr_done_latency", 32'(cyc - acc), 32'd4);
    @(negedge clk);
    check1("wr_done_single", wr_done, 1'b0);
    check1("ready_after_wb", req_ready, 1'b1);
  endtask

  task automatic refill(input logic [31:0] addr, input bit stray, output int acc);
    cap_clear();
    if (stray) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        wdata_valid = ~wdata_valid;
        wdata = $urandom;
      end
    end
    send_req(1'b0, addr, acc);
    for (int i = 0; i < L + LW + 1; i++) begin
      if (stray) begin
        wdata_valid = ~wdata_valid;
        wdata = $urandom;
      end
      @(negedge clk);
    end
    wdata_valid = 1'b0;
  endtask

  initial begin
    int acc, acc1, acc2, n;
    repeat (3) @(negedge clk);
    check1("reset_req_ready", req_ready, 1'b1);
    check1("reset_rdata_valid", rdata_valid, 1'b0);
    check("reset_rdata", rdata, 32'h0);
    #2 rst = 1'b0;

    // preload lines 0x40 and 0xC0
    wb(32'h40, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0);
    wb(32'hC0, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 1'b0);

    refill(32'h40, 1'b0, acc);
    check_burst("refill_40", 32'hA0, 32'hA1, 32'hA2, 32'hA3, acc);
    refill(32'h4C, 1'b0, acc);
    check_burst("refill_4c", 32'hA0, 32'hA1, 32'hA2, 32'hA3, acc);
    refill(32'h1040, 1'b0, acc);
    check_burst("refill_wrap", 32'hA0, 32'hA1, 32'hA2, 32'hA3, acc);

    wb(32'h80, 32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
    refill(32'h80, 1'b0, acc);
    check_burst("refill_80", 32'h11, 32'h22, 32'h33, 32'h44, acc);

    // continuous req_valid: second request only after the last beat
    cap_clear();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    acc1 = cyc + 1;
    @(negedge clk);
    n = 0;
    while (rdata_last !== 1'b1 && n < 20) begin
      check1("ready_busy", req_ready, 1'b0);
      @(negedge clk);
      n++;
    end
    check1("hold_last_seen", rdata_last, 1'b1);
    check1("ready_busy_last", req_ready, 1'b0);
    @(negedge clk);
    check1("ready_after_last", req_ready, 1'b1);
    req_addr = 32'h80;
    acc2 = cyc + 1;
    @(negedge clk);
    check1("second_accepted", req_ready, 1'b0);
    req_valid = 1'b0;
    check_burst("hold_first", 32'hA0, 32'hA1, 32'hA2, 32'hA3, acc1);
    cap_clear();
    repeat (L + LW + 2) @(negedge clk);
    check_burst("hold_second", 32'h11, 32'h22, 32'h33, 32'h44, acc2);

    // reset after two of four writeback words
    send_req(1'b1, 32'hC0, acc);
    wdata_valid = 1'b1; wdata = 32'h5A5A_0000;
    @(negedge clk);
    wdata = 32'h5A5A_0001;
    @(negedge clk);
    wdata_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check1("midrst_req_ready", req_ready, 1'b1);
    check1("midrst_wdata_ready", wdata_ready, 1'b0);
    check1("midrst_rdata_valid", rdata_valid, 1'b0);
    check1("midrst_rdata_last", rdata_last, 1'b0);
    check1("midrst_wr_done", wr_done, 1'b0);
    check("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    refill(32'hC0, 1'b0, acc);
    check_burst("refill_c0", 32'h5A5A_0000, 32'h5A5A_0001, 32'hF2, 32'hF3, acc);

    // stray write data in IDLE and RBURST leaves storage alone
    refill(32'h80, 1'b1, acc);
    check_burst("stray_80", 32'h11, 32'h22, 32'h33, 32'h44, acc);
    refill(32'h40, 1'b0, acc);
    check_burst("after_stray_40", 32'hA0, 32'hA1, 32'hA2, 32'hA3, acc);
    refill(32'h80, 1'b0, acc);
    check_burst("after_stray_80", 32'h11, 32'h22, 32'h33, 32'h44, acc);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
